// File: rtl/seg_display_pkg.sv
// Shared types and constants for the seven-segment display arbitration slice.
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;

  typedef logic [DIGIT_W-1:0]            digit_t;
  typedef logic [NUM_DIGITS*DIGIT_W-1:0] disp_value_t;

  typedef enum logic {IDLE, OWNED} arb_state_t;

endpackage

// File: rtl/seg_rr_picker.sv
// Combinational round-robin search: first set req index after 'last', wrapping.
module seg_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // Scanning the farthest candidate first lets the nearest one overwrite it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(last) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit display with a minimum dwell per grant.
module seg_display_arbiter
  import seg_display_pkg::*;
#(
  parameter int          NUM_REQ     = 3,
  parameter int          HOLD_CYCLES = 100_000_000,
  parameter disp_value_t IDLE_VALUE  = 16'h0000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*16-1:0]           value,
  input  logic [NUM_REQ*NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            busy,
  output digit_t                          num3,
  output digit_t                          num2,
  output digit_t                          num1,
  output digit_t                          num0,
  output logic [NUM_DIGITS-1:0]           dpSelector
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_t              state, state_n;
  logic [IDX_W-1:0]        last, last_n;
  logic [CNT_W-1:0]        hold_cnt, hold_cnt_n;
  disp_value_t             disp_q, disp_n;
  logic [NUM_DIGITS-1:0]   dp_q, dp_n;

  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;

  seg_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req   (req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // While OWNED, 'last' is the owner, so the search from last+1 reaches the
  // owner only after every other client; pick_idx != last means a competitor.
  always_comb begin
    state_n    = state;
    last_n     = last;
    hold_cnt_n = hold_cnt;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_n    = OWNED;
          last_n     = pick_idx;
          hold_cnt_n = '0;
        end
      end
      OWNED: begin
        if (!req[last]) begin
          hold_cnt_n = '0;
          if (pick_found) last_n  = pick_idx;
          else            state_n = IDLE;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end else if (pick_idx != last) begin
          last_n     = pick_idx;
          hold_cnt_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Display data follows the owner chosen for the next cycle so it lands with the grant.
  always_comb begin
    disp_n = IDLE_VALUE;
    dp_n   = '0;
    if (state_n == OWNED) begin
      disp_n = value[int'(last_n)*16 +: 16];
      dp_n   = dp_mask[int'(last_n)*NUM_DIGITS +: NUM_DIGITS];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      last     <= LAST_RST;
      hold_cnt <= '0;
      disp_q   <= IDLE_VALUE;
      dp_q     <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      hold_cnt <= hold_cnt_n;
      disp_q   <= disp_n;
      dp_q     <= dp_n;
    end
  end

  assign busy       = (state == OWNED);
  assign grant      = busy ? (NUM_REQ'(1) << last) : '0;
  assign num3       = disp_q[3*DIGIT_W +: DIGIT_W];
  assign num2       = disp_q[2*DIGIT_W +: DIGIT_W];
  assign num1       = disp_q[1*DIGIT_W +: DIGIT_W];
  assign num0       = disp_q[0*DIGIT_W +: DIGIT_W];
  assign dpSelector = dp_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an owner/age model.
module tb_seg_display_arbiter;

  localparam int NR   = 3;
  localparam int HOLD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [47:0]   value = '0;
  logic [11:0]   dp_mask = '0;
  logic [NR-1:0] grant;
  logic          busy;
  logic [3:0]    num3, num2, num1, num0;
  logic [3:0]    dpSelector;

  int n_checks = 0;
  int n_fail   = 0;

  seg_display_arbiter #(.NUM_REQ(NR), .HOLD_CYCLES(HOLD), .IDLE_VALUE(16'h0000)) dut (
    .clk(clk), .rst(rst), .req(req), .value(value), .dp_mask(dp_mask),
    .grant(grant), .busy(busy), .num3(num3), .num2(num2), .num1(num1), .num0(num0),
    .dpSelector(dpSelector)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 idle), pointer, and how many cycles the owner has held.
  int          m_owner = -1;
  int          m_last  = NR - 1;
  int          m_age   = 0;
  logic [15:0] m_disp  = 16'h0000;
  logic [3:0]  m_dp    = 4'h0;
  bit          m_valid = 1'b0;

  function automatic int pick(input logic [NR-1:0] r, input int from_last);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (from_last + k) % NR;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int p;
    m_valid = 1'b1;
    if (rst) begin
      m_owner = -1; m_last = NR - 1; m_age = 0;
    end else begin
      p = pick(req, m_last);
      if (m_owner < 0 || !req[m_owner] || (m_age >= HOLD && p != m_owner)) begin
        m_owner = p;
        m_age   = 1;
        if (p >= 0) m_last = p;
      end else begin
        m_age++;
      end
    end
    if (m_owner >= 0) begin
      m_disp = value[m_owner*16 +: 16];
      m_dp   = dp_mask[m_owner*4 +: 4];
    end else begin
      m_disp = 16'h0000;
      m_dp   = 4'h0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("grant", 32'(grant), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("digits", 32'({num3, num2, num1, num0}), 32'(m_disp));
      check("dp", 32'(dpSelector), 32'(m_dp));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] seq [4];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;

    // Reset then idle.
    rst = 1'b1; req = '0;
    step(2);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_digits", 32'({num3, num2, num1, num0}), 32'h0);
    check("rst_dp", 32'(dpSelector), 32'h0);
    rst = 1'b0;
    step(2);
    check("idle_grant", 32'(grant), 32'd0);

    // Single client.
    value = {16'h3333, 16'h2222, 16'h1A2F};
    dp_mask = {4'b0001, 4'b0010, 4'b0100};
    req = 3'b001;
    step();
    check("single_grant", 32'(grant), 32'b001);
    check("single_digits", 32'({num3, num2, num1, num0}), 32'h1A2F);
    check("single_dp", 32'(dpSelector), 32'b0100);
    step(12);
    check("single_persist", 32'(grant), 32'b001);
    value[15:0] = 16'h5555;
    step();
    check("live_value", 32'({num3, num2, num1, num0}), 32'h5555);

    // Dwell and rotation.
    do_reset();
    req = 3'b111;
    step();
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < HOLD; k++) begin
        check($sformatf("rot_s%0d_k%0d", s, k), 32'(grant), 32'(seq[s]));
        step();
      end
    end

    // Early release with a waiting competitor.
    do_reset();
    req = 3'b010;
    step();
    req = 3'b110;
    step(3);
    check("early_cnt3", 32'(dut.hold_cnt), 32'd3);
    check("early_owner", 32'(grant), 32'b010);
    req = 3'b100;
    step();
    check("early_switch", 32'(grant), 32'b100);
    check("early_cnt0", 32'(dut.hold_cnt), 32'd0);

    // Early release with nobody waiting.
    do_reset();
    req = 3'b010;
    step(4);
    req = 3'b000;
    step();
    check("release_idle", 32'(grant), 32'd0);
    check("release_digits", 32'({num3, num2, num1, num0}), 32'h0);

    // Expired-owner preemption.
    do_reset();
    req = 3'b001;
    step(20);
    req = 3'b101;
    step();
    check("preempt", 32'(grant), 32'b100);

    // Reset mid-operation.
    do_reset();
    req = 3'b100;
    step();
    check("mid_pre", 32'(grant), 32'b100);
    req = 3'b110;
    rst = 1'b1;
    step();
    check("mid_rst", 32'(grant), 32'd0);
    rst = 1'b0;
    step();
    check("mid_after", 32'(grant), 32'b010);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = NR'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) value = {16'($urandom), 16'($urandom), 16'($urandom)};
      if ($urandom_range(0, 4) == 0) dp_mask = 12'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    req = '0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Time-shares the board's single 4-digit seven-segment display between `NUM_REQ` requesting clients (counters, status monitors, debug taps). It sits directly upstream of the seven-segment display controller and drives that controller's `num3..num0` and `dpSelector` inputs. Clients raise `req` with their 16-bit hex value and decimal-point mask. The arbiter grants the display round-robin, holds each grant for a minimum dwell time, and shows an idle pattern when nobody requests.

## Interface
- `NUM_REQ`, default 3: number of requesting clients, 2..8.
- `HOLD_CYCLES`, default 100_000_000: dwell time in clk cycles before a pending requester may take over (1 s at 100 MHz). Minimum value is 2.
- `IDLE_VALUE`, default 16'h0000: value shown on `num3..num0` while idle. `dpSelector` is 4'b0000 while idle.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-client request; level, held while the client wants the display.
- `value`  in  NUM_REQ*16  client i's value at bits [16i+15:16i]. Nibble 3 is the leftmost digit.
- `dp_mask`  in  NUM_REQ*4  client i's decimal-point mask at bits [4i+3:4i].
- `grant`  out  NUM_REQ  one-hot current owner, or all zero when idle.
- `busy`  out  1  high when any client owns the display.
- `num3`, `num2`, `num1`, `num0`  out  4 each  digit nibbles to the display controller.
- `dpSelector`  out  4  decimal-point enables to the display controller.

## Operation
- FSM with two states:
  - IDLE: `grant`=0 and `busy`=0.
  - OWNED: exactly one `grant` bit is set and `busy`=1.
- Round-robin pointer `last` holds the index of the most recent owner. Reset value is NUM_REQ-1, so client 0 wins first.
- Pick function: the first index with `req` set, searching from (`last`+1) mod NUM_REQ upward with wrap.
- IDLE -> OWNED: when any `req` is set, grant the picked index. Set `last` to that index and clear `hold_cnt` to 0.
- OWNED, owner drops `req`:
  - If others are requesting, switch directly to the picked index. There is no idle cycle between owners.
  - Otherwise go to IDLE.
  - This applies regardless of `hold_cnt`.
- OWNED, owner still requesting, with `hold_cnt` < HOLD_CYCLES-1: increment `hold_cnt`.
- OWNED, owner still requesting, with `hold_cnt` = HOLD_CYCLES-1 (dwell expired):
  - If another client requests, switch to the picked index and clear `hold_cnt`.
  - If no other client requests, keep the owner and hold `hold_cnt` at HOLD_CYCLES-1. An expired owner is therefore preempted on the first cycle any other `req` rises.
- A drop by the owner in the same cycle as expiry is handled as a drop; the outcome is identical.
- Output datapath: every cycle, `num3..num0` and `dpSelector` are registered from the `value`/`dp_mask` slice of the owner selected for the next cycle. In IDLE they take `IDLE_VALUE` and 4'b0000.
- The owner's value is live: changes in the owner's `value` track through with one cycle of latency.
- `hold_cnt` width is $clog2(HOLD_CYCLES). The counter never wraps.

## Timing
- Reset values: `grant`=0, `busy`=0, `num3..num0` = `IDLE_VALUE` nibbles, `dpSelector`=0, `hold_cnt`=0, `last`=NUM_REQ-1, state IDLE.
- `rst` asserted mid-grant clears everything on the next edge. A `req` still high after reset release is re-arbitrated from the reset pointer.
- Latency: a `req` rising before edge n gives `grant`/`busy` high after edge n. `num*`/`dpSelector` carry that client's value after the same edge n, because the next owner is computed combinationally and both paths register together.
- Owner change from the owner's `req` drop: a `req` falling before edge n updates `grant` and the display data after edge n.
- Dwell: for a continuously requesting owner with a competitor waiting, the grant lasts exactly HOLD_CYCLES cycles.
- Clients must not assume a grant within any bound other than (NUM_REQ-1)*HOLD_CYCLES+1 cycles.

## Structure
- Package `seg_display_pkg`:
  - Constants `NUM_DIGITS`=4 and `DIGIT_W`=4.
  - `typedef logic [3:0] digit_t`.
  - `typedef logic [15:0] disp_value_t`.
  - `typedef enum logic {IDLE, OWNED} arb_state_t`.
- Sub-module `seg_rr_picker`: combinational round-robin search. Inputs are `req` and `last`; outputs are `found` and `idx`. It is parameterised by NUM_REQ and is reusable by other arbiters.
- All remaining logic lives in `seg_display_arbiter`: the FSM, `hold_cnt`, `last`, the output mux and the registers.

## Test plan
All scenarios use NUM_REQ=3, HOLD_CYCLES=8, IDLE_VALUE=16'h0000.
- Reset then idle: `rst` for 2 cycles with no `req` -> `grant`=000, `busy`=0, digits 0,0,0,0, `dpSelector`=0000 on every cycle.
- Single client: `req`=001, value0=16'h1A2F, dp0=4'b0100 -> after 1 edge `grant`=001, `num3..0`=1,A,2,F, `dpSelector`=0100. The grant persists beyond 8 cycles with no competitor.
- Dwell and rotation: `req`=111 held -> grant sequence 001, 010, 100, 001, each lasting exactly 8 cycles, with no idle gap between owners.
- Early release: client 1 owns with `hold_cnt`=3, then drops `req` while `req[2]`=1 -> next edge `grant`=100 and `hold_cnt`=0. If instead no others are requesting -> `grant`=000 and the digits show 0000.
- Expired-owner preemption: client 0 owns for 20 cycles, then `req[2]` rises -> the next edge gives `grant`=100.
- Reset mid-operation: `rst` during a grant to client 2 with `req`=110 still high -> `grant`=000, then after release `grant`=010, because the pointer reset makes the search start at index 0.
